// File: rtl/local_mem_pkg.sv
// Shared types and defaults for the LOCAL_MEM read path: widths, engine state
// encoding, the buffered-DW entry layout and a byte-reversal helper.
package local_mem_pkg;

  localparam int LM_ADDR_W = 10;
  localparam int LM_DATA_W = 32;
  localparam int LM_LEN_W  = 10;
  localparam int LM_TAG_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [LM_DATA_W-1:0] data;
    logic                 last;
    logic [LM_TAG_W-1:0]  tag;
  } fifo_entry_t;

  // Byte 0 of the input lands in the most significant byte of the result.
  function automatic logic [LM_DATA_W-1:0] byte_rev(input logic [LM_DATA_W-1:0] d);
    logic [LM_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < LM_DATA_W / 8; i++) begin
      r[8*i +: 8] = d[LM_DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/local_mem_rd_fifo.sv
// Synchronous output buffer for returned DWs. The head entry is read straight
// from registered storage, so it holds steady until it is popped.
module local_mem_rd_fifo
  import local_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fifo_entry_t      wr_entry,
  input  logic             pop,
  output fifo_entry_t      rd_entry,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/local_mem_rd_engine.sv
// Burst read engine in front of LOCAL_MEM: issues one address per cycle while
// the output FIFO has room, and streams returned DWs with last/tag sidebands.
// Optional macro LOCAL_MEM_RD_SWAP_EN byte-reverses each DW before buffering.
module local_mem_rd_engine
  import local_mem_pkg::*;
#(
  parameter int ADDR_W     = LM_ADDR_W,
  parameter int DATA_W     = LM_DATA_W,
  parameter int LEN_W      = LM_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [7:0]        req_tag,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic [7:0]        dout_tag,
  output logic              busy
);

  // state | meaning
  // IDLE  | no burst active; request port open
  // READ  | issuing addresses, one per cycle while FIFO credit remains

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W:0]    remain_q;
  logic [7:0]        tag_q;
  logic              rd_pend_q;
  logic              last_pend_q;
  logic [7:0]        tag_pend_q;

  logic              accept;
  logic              issue;
  logic              credit;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  fifo_entry_t       wr_entry;
  fifo_entry_t       rd_entry;

  // The in-flight read already owns a FIFO slot, so it counts against credit.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
  assign credit    = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = READ;
        end
      end
      READ: begin
        if (credit) begin
          issue = 1'b1;
          if (remain_q == (LEN_W + 1)'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remain_q    <= '0;
      tag_q       <= '0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      tag_pend_q  <= '0;
    end else begin
      rd_pend_q <= issue;
      if (accept) begin
        addr_q   <= req_addr;
        remain_q <= (req_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len};
        tag_q    <= req_tag;
      end else if (issue) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
      // Sidebands travel with the read, since tag_q may be reloaded meanwhile.
      if (issue) begin
        last_pend_q <= (remain_q == (LEN_W + 1)'(1));
        tag_pend_q  <= tag_q;
      end
    end
  end

`ifdef LOCAL_MEM_RD_SWAP_EN
  assign push_data = byte_rev(mem_dout);
`else
  assign push_data = mem_dout;
`endif

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = push_data;
    wr_entry.last = last_pend_q;
    wr_entry.tag  = tag_pend_q;
  end

  local_mem_rd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend_q),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (rd_entry),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign pop        = dout_valid && dout_ready;
  assign dout_valid = !fifo_empty;
  assign dout_data  = rd_entry.data;
  assign dout_last  = rd_entry.last;
  assign dout_tag   = rd_entry.tag;

  assign mem_we   = 1'b0;
  assign mem_din  = '0;
  assign mem_addr = addr_q;
  assign busy     = (state_q == READ) || rd_pend_q || !fifo_empty;

endmodule

// File: tb/tb_local_mem_rd_engine.sv
// Scoreboard bench for local_mem_rd_engine with a one-cycle-latency memory
// model whose word at address a holds bytes {a+3, a+2, a+1, a}.
module tb_local_mem_rd_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [9:0]  req_len;
  logic [7:0]  req_tag;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        dout_last;
  logic [7:0]  dout_tag;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  tag;
  } beat_t;

  beat_t sb_q[$];
  beat_t mb;
  int    checks = 0;
  int    errors = 0;
  int    pops   = 0;
  int    p0;

  always #5 clk = ~clk;

  local_mem_rd_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_tag    (req_tag),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .dout_tag   (dout_tag),
    .busy       (busy)
  );

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    logic [7:0] b;
    b = a[7:0];
`ifdef LOCAL_MEM_RD_SWAP_EN
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
`else
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
`endif
  endfunction

  always @(posedge clk) mem_dout <= mem_word(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      pops++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h tag 0x%0h, expected none", dout_data, dout_tag);
      end else begin
        mb = sb_q.pop_front();
        check("beat_data", dout_data, mb.data);
        check("beat_last", 32'(dout_last), 32'(mb.last));
        check("beat_tag", 32'(dout_tag), 32'(mb.tag));
      end
    end
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
    check({pfx, "_mem_din"}, mem_din, 32'd0);
    check({pfx, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({pfx, "_dout_data"}, dout_data, 32'd0);
    check({pfx, "_dout_last"}, 32'(dout_last), 32'd0);
    check({pfx, "_dout_tag"}, 32'(dout_tag), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called away from the rising edge; returns 1ns after the accepting edge.
  task automatic send_req(input logic [9:0] addr, input logic [9:0] len, input logic [7:0] tag);
    int n;
    int k;
    beat_t b;
    logic [9:0] a;
    n = (len == 10'd0) ? 1024 : int'(len);
    k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got %b, expected 1", req_ready);
    end
    for (int i = 0; i < n; i++) begin
      a      = addr + 10'(i);
      b.data = exp_word(a);
      b.last = (i == n - 1);
      b.tag  = tag;
      sb_q.push_back(b);
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    req_tag   = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats pending busy=%b, expected 0 and 0", name, sb_q.size(), busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] a;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    req_tag    = '0;
    dout_ready = 1'b0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);

    // Single DW: latency T+3 and busy clears right after
    send_req(10'h005, 10'd1, 8'h11);
    @(negedge clk);
    check("t1_valid_t1", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_t2", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_t3", 32'(dout_valid), 32'd1);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Eight back-to-back beats
    send_req(10'h010, 10'd8, 8'h22);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_stream_valid", 32'(dout_valid), 32'd1);
    end
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);

    // Address wrap
    send_req(10'h3FE, 10'd4, 8'h33);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 10'h3FE + 10'(i);
      check("t3_mem_addr", 32'(mem_addr), 32'(a));
    end
    wait_drain("t3", 50);

    // Backpressure: FIFO fills, issue stalls
    dout_ready = 1'b0;
    p0 = pops;
    send_req(10'h010, 10'd8, 8'h44);
    repeat (12) @(negedge clk);
    check("t4_valid_held", 32'(dout_valid), 32'd1);
    check("t4_mem_addr_hold", 32'(mem_addr), 32'h014);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_pending", 32'(sb_q.size()), 32'd8);
    dout_ready = 1'b1;
    wait_drain("t4", 50);
    check("t4_beat_count", 32'(pops - p0), 32'd8);

    // Two back-to-back requests
    p0 = pops;
    send_req(10'h020, 10'd3, 8'h01);
    send_req(10'h030, 10'd2, 8'h02);
    wait_drain("t5", 50);
    check("t5_beat_count", 32'(pops - p0), 32'd5);

    // Reset mid-burst
    send_req(10'h040, 10'd16, 8'h55);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_stale", 32'(dout_valid), 32'd0);
    end
    p0 = pops;
    send_req(10'h007, 10'd1, 8'h66);
    wait_drain("t6", 50);
    check("t6_beat_count", 32'(pops - p0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/local_mem_rd_engine.md
# local_mem_rd_engine

Read-request engine sitting directly upstream of LOCAL_MEM in the PCIe endpoint. It accepts a DW-addressed burst read request, streams addresses into LOCAL_MEM one per cycle, absorbs its one-cycle read latency, and buffers the returned DWs in a small FIFO. The buffered DWs are presented to the completion builder over a valid/ready stream with last and tag sidebands.

## Interface
- ADDR_W, 10, LOCAL_MEM DW address width
- DATA_W, 32, DW width
- LEN_W, 10, request length field width; value 0 means 2^LEN_W DWs
- FIFO_DEPTH, 4, output buffer entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  read request valid
- req_ready  out  1  engine accepts request, high only in IDLE
- req_addr  in  ADDR_W  start DW address
- req_len  in  LEN_W  length in DWs, 0 = 1024
- req_tag  in  8  opaque tag returned with data
- mem_we  out  1  tied 0
- mem_addr  out  ADDR_W  address to LOCAL_MEM
- mem_din  out  DATA_W  tied 0
- mem_dout  in  DATA_W  LOCAL_MEM read data, valid the cycle after address
- dout_valid  out  1  stream data valid
- dout_ready  in  1  consumer ready
- dout_data  out  DATA_W  read DW
- dout_last  out  1  final DW of a request
- dout_tag  out  8  tag of the owning request
- busy  out  1  state READ, read in flight, or FIFO non-empty

## Operation
- States: IDLE, READ. Reset → IDLE.
- IDLE: req_ready=1; on req_valid&&req_ready capture addr_q=req_addr, remain_q=req_len (0 → 1024), tag_q=req_tag; → READ.
- READ: issue when credit: fifo_count + rd_pend < FIFO_DEPTH. On issue: mem_addr=addr_q, addr_q += 1 (mod 2^ADDR_W, wraps 0x3FF→0x000), remain_q -= 1, rd_pend<=1 with last=(remain_q==1) and tag_q. No credit → stall, mem_addr holds, no issue.
- After issuing the final DW → IDLE in the next cycle; a new request may be accepted while the previous request's data still drains. Data of successive requests never reorders.
- rd_pend set: the cycle after issue, push {mem_dout, last, tag} into FIFO.
- FIFO push and pop in the same cycle is legal; count unchanged. Credit rule guarantees no overflow; pop only on dout_valid&&dout_ready.
- dout_valid = FIFO non-empty; dout_data/last/tag hold stable while dout_valid && !dout_ready.
- Reset mid-burst: all state, FIFO contents and rd_pend cleared immediately; no partial data emitted after release.
- Reset values: req_ready=1 (IDLE), mem_addr=0, mem_we=0, mem_din=0, dout_valid=0, dout_data=0, dout_last=0, dout_tag=0, busy=0.

## Timing
- Request accepted at edge T → first address on mem_addr during cycle T+1 → mem_dout valid T+2 → pushed at edge ending T+2 → dout_valid during T+3.
- Sustained throughput 1 DW/cycle with dout_ready held high; an N-DW request occupies READ for N cycles.
- Credit accounts for the in-flight read, so dout_ready low stalls issue within one cycle without losing data.

## Configuration
- LOCAL_MEM_RD_SWAP_EN defined: each DW byte-reversed before FIFO push (dout_data[7:0]=mem_dout[31:24], etc.) for big-endian TLP payload.
- Undefined: mem_dout passed unchanged. Latency identical both ways.

## Structure
- Shared package local_mem_pkg: ADDR_W, DATA_W, LEN_W defaults, state enum {IDLE, READ}, FIFO entry struct {data, last, tag}.
- One sub-module: local_mem_rd_fifo (synchronous FIFO, FIFO_DEPTH entries, count output, registered-stable head).

## Test plan
- Reset release, req addr=0x005 len=1 tag=0x11, dout_ready=1 → one beat at T+3: data 0x08070605, last=1, tag=0x11; with LOCAL_MEM_RD_SWAP_EN data 0x05060708.
- addr=0x010 len=8, dout_ready=1 → 8 back-to-back beats, data 0x13121110 … 0x1A191817, last only on beat 8, busy low the cycle after.
- addr=0x3FE len=4 → mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- len=8 with dout_ready=0 → exactly FIFO_DEPTH=4 beats buffered, issue stalls, mem_addr holds 0x014; release ready → remaining 4 beats, no loss or duplication.
- Two back-to-back requests (tags 0x01 len 3, 0x02 len 2) → 5 beats in order, last on beats 3 and 5, tags correct per beat.
- rst_n low mid-burst of len 16 → outputs at reset values immediately; after release, no stale beats and new request len=1 completes normally.
